dmem_ctrl: RTL and testbench

- Multi-cycle data-memory controller directly downstream of the pipelined datapath's MEM stage.
- Consumes DM_readEnable, DM_writeEnable, DM_addr and DM_writeData; returns DM_readData.
- Runs a req/ack handshake to a variable-latency word memory.
- Raises stall so the pipeline freezes EX_MEM/MEM_WB until the access completes. Also flags misaligned accesses and memory timeouts.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_if.sv | 24 ++
 rtl/wait_counter.sv | 28 ++
 rtl/dmem_ctrl.sv | 113 +++++++++++
 tb/tb_dmem_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// The state enum, default sizes and the word-alignment mask live here.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;

    localparam int DEFAULT_N       = 64;
    localparam int DEFAULT_MEM_AW  = 10;
    localparam int DEFAULT_TIMEOUT = 255;

    localparam logic [2:0] ALIGN_MASK = 3'b111;

    function automatic logic isAligned(input logic [2:0] lowBits);
        return (lowBits & ALIGN_MASK) == 3'b000;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/acknowledge bus between the controller (master) and the word memory (slave).
interface dmem_if
    import dmem_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int MEM_AW = DEFAULT_MEM_AW
);
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [N-1:0]      mem_wdata;
    logic              mem_ack;
    logic [N-1:0]      mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/wait_counter.sv
// Counts cycles while enabled; hit flags the last allowed cycle before a timeout.
module wait_counter #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic hit
);
    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] count;

    // Clear has priority so a counter leaving BUSY always restarts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign hit = en && (count == CW'(MAX - 1));

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller between the MEM stage and a variable-latency word memory.
// Freezes the pipeline via stall while an access is outstanding; flags misalignment and timeouts.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int MEM_AW  = DEFAULT_MEM_AW,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         DM_readEnable,
    input  logic         DM_writeEnable,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    output logic [N-1:0] DM_readData,
    output logic         stall,
    output logic         misaligned,
    output logic         timeout_err,
    dmem_if.master       mem
);

    dmem_state_t  state, stateNext;
    logic [N-1:0] readDataReg;
    logic         req, aligned, startAccess, timeoutHit, leaveBusy, inBusy;
    logic         unusedAddrBits;

    assign req       = DM_readEnable | DM_writeEnable;
    assign aligned   = isAligned(DM_addr[2:0]);
    assign inBusy    = (state == BUSY);
    assign leaveBusy = inBusy && (mem.mem_ack || timeoutHit);

    // Only the word-address slice reaches memory; the upper byte-address bits are ignored.
    assign unusedAddrBits = ^DM_addr[N-1:MEM_AW+3];

    wait_counter #(.MAX(TIMEOUT)) waitCounter (
        .clk   (clk),
        .reset (reset),
        .en    (inBusy),
        .clr   (leaveBusy),
        .hit   (timeoutHit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Stall and misaligned are forced low while reset is held so the pipeline never freezes in reset.
    always_comb begin
        stateNext   = state;
        startAccess = 1'b0;
        stall       = 1'b0;
        misaligned  = 1'b0;
        case (state)
            IDLE: begin
                if (req && aligned) begin
                    startAccess = 1'b1;
                    stall       = 1'b1;
                    stateNext   = BUSY;
                end else if (req) begin
                    misaligned = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (leaveBusy) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (!reset) begin
            stall      = 1'b0;
            misaligned = 1'b0;
        end
    end

    // An ack in the same cycle as the timeout hit completes the access normally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            readDataReg   <= '0;
            timeout_err   <= 1'b0;
        end else if (startAccess) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= DM_writeEnable;
            mem.mem_addr  <= DM_addr[MEM_AW+2:3];
            mem.mem_wdata <= DM_writeData;
        end else if (leaveBusy) begin
            mem.mem_req <= 1'b0;
            if (mem.mem_ack) begin
                if (!mem.mem_we) begin
                    readDataReg <= mem.mem_rdata;
                end
            end else begin
                readDataReg <= '0;
                timeout_err <= 1'b1;
            end
        end
    end

    // A rejected misaligned load returns zero for that cycle without disturbing the held value.
    assign DM_readData = misaligned ? '0 : readDataReg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, hand-written reset and back-to-back
// sequences, then randomized accesses against a word-array memory model.
module tb_dmem_ctrl;

    localparam int N      = 64;
    localparam int MEM_AW = 10;
    localparam int T      = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          dmReadEnable = 1'b0;
    logic          dmWriteEnable = 1'b0;
    logic [N-1:0]  dmAddr = '0;
    logic [N-1:0]  dmWriteData = '0;
    logic [N-1:0]  dmReadData;
    logic          stall, misaligned, timeoutErr;

    dmem_if #(.N(N), .MEM_AW(MEM_AW)) memBus ();

    dmem_ctrl #(.N(N), .MEM_AW(MEM_AW), .TIMEOUT(T)) dut (
        .clk            (clk),
        .reset          (reset),
        .DM_readEnable  (dmReadEnable),
        .DM_writeEnable (dmWriteEnable),
        .DM_addr        (dmAddr),
        .DM_writeData   (dmWriteData),
        .DM_readData    (dmReadData),
        .stall          (stall),
        .misaligned     (misaligned),
        .timeout_err    (timeoutErr),
        .mem            (memBus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int reqPulses = 0;

    always @(posedge memBus.mem_req) reqPulses++;

    typedef struct {
        logic              re;
        logic              we;
        logic [63:0]       addr;
        logic [63:0]       wdata;
        int                ackAt;
        logic [63:0]       rdata;
        int                expStall;
        logic              expMis;
        logic [MEM_AW-1:0] expAddr;
        logic [63:0]       expRead;
        logic              expTo;
    } vector_t;

    vector_t     vectors[$];
    logic [63:0] memModel[int];
    logic [63:0] modelRead;
    logic        modelTo;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Entered and left just after a rising edge; ackAt is the cycle mem_ack is driven (0 = never).
    task automatic applyStimulus(input string tag, input logic re, input logic we,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input int ackAt, input logic [63:0] rdata,
                                 input int expStall, input logic expMis,
                                 input logic [MEM_AW-1:0] expAddr,
                                 input logic [63:0] expRead, input logic expTo);
        dmReadEnable  = re;
        dmWriteEnable = we;
        dmAddr        = addr;
        dmWriteData   = wdata;
        memBus.mem_rdata = rdata;
        if (!(re | we)) begin
            memBus.mem_ack = 1'b1;
            @(negedge clk);
            checkOutput({tag, " idle stall"}, stall, 1'b0);
            checkOutput({tag, " idle memReq"}, memBus.mem_req, 1'b0);
            @(posedge clk); #1;
            memBus.mem_ack = 1'b0;
            @(negedge clk);
            checkOutput({tag, " strayAck memReq"}, memBus.mem_req, 1'b0);
            checkOutput({tag, " strayAck stall"}, stall, 1'b0);
            @(posedge clk); #1;
        end else if (expMis) begin
            memBus.mem_ack = 1'b0;
            @(negedge clk);
            checkOutput({tag, " misaligned"}, misaligned, 1'b1);
            checkOutput({tag, " mis stall"}, stall, 1'b0);
            checkOutput({tag, " mis readData"}, dmReadData, 64'h0);
            checkOutput({tag, " mis memReq"}, memBus.mem_req, 1'b0);
            @(posedge clk); #1;
            dmReadEnable  = 1'b0;
            dmWriteEnable = 1'b0;
            @(negedge clk);
            checkOutput({tag, " mis memReq next"}, memBus.mem_req, 1'b0);
            @(posedge clk); #1;
        end else begin
            for (int c = 0; c <= expStall; c++) begin
                memBus.mem_ack = (ackAt >= 1) && (c == ackAt);
                @(negedge clk);
                if (c < expStall) begin
                    checkOutput($sformatf("%s stall c%0d", tag, c), stall, 1'b1);
                    checkOutput($sformatf("%s memReq c%0d", tag, c), memBus.mem_req, c >= 1);
                    if (c == 0) checkOutput({tag, " misaligned"}, misaligned, 1'b0);
                    if (c >= 1) begin
                        checkOutput($sformatf("%s memAddr c%0d", tag, c), memBus.mem_addr, expAddr);
                        checkOutput($sformatf("%s memWe c%0d", tag, c), memBus.mem_we, we);
                        checkOutput($sformatf("%s memWdata c%0d", tag, c), memBus.mem_wdata, wdata);
                    end
                end else begin
                    checkOutput({tag, " done stall"}, stall, 1'b0);
                    checkOutput({tag, " done memReq"}, memBus.mem_req, 1'b0);
                    checkOutput({tag, " done readData"}, dmReadData, expRead);
                    checkOutput({tag, " done timeoutErr"}, timeoutErr, expTo);
                end
                @(posedge clk); #1;
            end
        end
        dmReadEnable   = 1'b0;
        dmWriteEnable  = 1'b0;
        memBus.mem_ack = 1'b0;
    endtask

    task automatic resetDut();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset timeoutErr", timeoutErr, 1'b0);
        checkOutput("reset readData", dmReadData, 64'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        modelRead = '0;
        modelTo   = 1'b0;
    endtask

    initial begin
        int          kind, word, ackAt, expStall, pulsesBefore;
        logic        re, we, acked, mis;
        logic [63:0] addr, wdata, rdata;

        memBus.mem_ack   = 1'b0;
        memBus.mem_rdata = '0;

        // Reset held with a load pending must not stall or issue.
        dmReadEnable = 1'b1;
        dmAddr       = 64'h28;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstHold memReq", memBus.mem_req, 1'b0);
        checkOutput("rstHold stall", stall, 1'b0);
        checkOutput("rstHold readData", dmReadData, 64'h0);
        checkOutput("rstHold timeoutErr", timeoutErr, 1'b0);
        @(posedge clk); #1;
        dmReadEnable = 1'b0;
        reset = 1'b1;

        vectors.push_back('{1'b1, 1'b0, 64'h28, 64'h0, 1, 64'hDEADBEEF, 2, 1'b0, 10'd5, 64'hDEADBEEF, 1'b0});
        vectors.push_back('{1'b0, 1'b1, 64'h40, 64'h1234, 3, 64'hBAD, 4, 1'b0, 10'd8, 64'hDEADBEEF, 1'b0});
        vectors.push_back('{1'b1, 1'b0, 64'h2C, 64'h0, 1, 64'h0, 0, 1'b1, 10'd0, 64'h0, 1'b0});
        vectors.push_back('{1'b0, 1'b1, 64'h41, 64'h77, 1, 64'h0, 0, 1'b1, 10'd0, 64'h0, 1'b0});
        vectors.push_back('{1'b1, 1'b1, 64'h18, 64'hAAAA, 2, 64'h5555, 3, 1'b0, 10'd3, 64'hDEADBEEF, 1'b0});
        vectors.push_back('{1'b1, 1'b0, 64'h30, 64'h0, 4, 64'hCAFE, 5, 1'b0, 10'd6, 64'hCAFE, 1'b0});
        vectors.push_back('{1'b1, 1'b0, 64'h38, 64'h0, 0, 64'h1, 5, 1'b0, 10'd7, 64'h0, 1'b1});
        vectors.push_back('{1'b1, 1'b0, 64'h08, 64'h0, 2, 64'h0123456789ABCDEF, 3, 1'b0, 10'd1, 64'h0123456789ABCDEF, 1'b1});
        vectors.push_back('{1'b1, 1'b0, 64'hFFFF000000001FF8, 64'h0, 1, 64'h77, 2, 1'b0, 10'h3FF, 64'h77, 1'b1});
        vectors.push_back('{1'b0, 1'b1, 64'h48, 64'h99, 0, 64'h0, 5, 1'b0, 10'd9, 64'h0, 1'b1});

        @(posedge clk); #1;
        foreach (vectors[i]) begin
            applyStimulus($sformatf("vec%0d", i), vectors[i].re, vectors[i].we, vectors[i].addr,
                          vectors[i].wdata, vectors[i].ackAt, vectors[i].rdata, vectors[i].expStall,
                          vectors[i].expMis, vectors[i].expAddr, vectors[i].expRead, vectors[i].expTo);
        end

        resetDut();

        // Back-to-back load then store, bracketed by stray acks in IDLE.
        applyStimulus("b2b pre", 1'b0, 1'b0, 64'h0, 64'h0, 0, 64'h0, 0, 1'b0, 10'd0, 64'h0, 1'b0);
        pulsesBefore = reqPulses;
        applyStimulus("b2b load", 1'b1, 1'b0, 64'h08, 64'h0, 1, 64'h11, 2, 1'b0, 10'd1, 64'h11, 1'b0);
        applyStimulus("b2b store", 1'b0, 1'b1, 64'h10, 64'h22, 2, 64'h33, 3, 1'b0, 10'd2, 64'h11, 1'b0);
        applyStimulus("b2b post", 1'b0, 1'b0, 64'h0, 64'h0, 0, 64'h0, 0, 1'b0, 10'd0, 64'h0, 1'b0);
        checkOutput("b2b reqPulses", reqPulses - pulsesBefore, 2);

        // Reset asserted while BUSY abandons the access without retry.
        dmReadEnable = 1'b1;
        dmAddr       = 64'h50;
        @(posedge clk); #1;
        checkOutput("rstBusy memReq before", memBus.mem_req, 1'b1);
        reset = 1'b0;
        #1;
        checkOutput("rstBusy memReq async", memBus.mem_req, 1'b0);
        checkOutput("rstBusy stall", stall, 1'b0);
        checkOutput("rstBusy readData", dmReadData, 64'h0);
        dmReadEnable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstBusy idle memReq", memBus.mem_req, 1'b0);
        checkOutput("rstBusy idle stall", stall, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rstBusy noRetry memReq", memBus.mem_req, 1'b0);
        @(posedge clk); #1;
        applyStimulus("rstBusy after", 1'b1, 1'b0, 64'h50, 64'h0, 1, 64'h5A, 2, 1'b0, 10'd10, 64'h5A, 1'b0);

        resetDut();

        for (int i = 0; i < 80; i++) begin
            kind  = $urandom_range(0, 5);
            word  = $urandom_range(0, 15);
            addr  = ({$urandom, $urandom} << 13) | (64'(word) << 3);
            wdata = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            ackAt = $urandom_range(1, T + 1);
            re    = (kind == 1) || (kind == 2) || (kind == 4) || ((kind == 5) && $urandom_range(0, 1) == 1);
            we    = (kind == 3) || (kind == 4) || ((kind == 5) && !re);
            mis   = (kind == 5);
            if (mis) addr = addr | 64'($urandom_range(1, 7));
            acked    = (ackAt <= T);
            expStall = acked ? ackAt + 1 : T + 1;
            if (!mis && (re | we)) begin
                if (re && !we) begin
                    if (memModel.exists(word)) rdata = memModel[word];
                    else memModel[word] = rdata;
                end
                if (!acked) begin
                    modelRead = '0;
                    modelTo   = 1'b1;
                end else if (we) begin
                    memModel[word] = wdata;
                end else begin
                    modelRead = rdata;
                end
            end
            applyStimulus($sformatf("rnd%0d", i), re, we, addr, wdata, ackAt, rdata,
                          mis ? 0 : expStall, mis, MEM_AW'(addr >> 3), modelRead, modelTo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
